uno_horner_seq: RTL and testbench

Iterative polynomial evaluator directly downstream of the PE scale generator. It accepts an operand pair plus the registered scale word and runs a multi-cycle Horner evaluation on the fractional part of x for the unary ops (div, exp, log). It multiplies the polynomial result by the scale and presents it on a valid/ready output. For gemm it issues a single fixed-point multiply of x and y.

---
 rtl/uno_horner_seq_if.sv | 25 ++
 rtl/uno_horner_seq.sv | 175 +++++++++++++++++
 tb/tb_uno_horner_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uno_horner_seq_if.sv
// Operand/result handshake bundle for uno_horner_seq.
// The master drives the operands and the result ready; the slave is the evaluator.
interface uno_horner_seq_if #(
  parameter int unsigned MUL_BW = 16
);
  logic [1:0]        gemm_uno;
  logic              in_valid;
  logic              in_ready;
  logic [MUL_BW-1:0] x_i;
  logic [MUL_BW-1:0] y_i;
  logic [MUL_BW-1:0] scale_i;
  logic              out_valid;
  logic              out_ready;
  logic [MUL_BW-1:0] result_o;

  modport master (
    output gemm_uno, in_valid, x_i, y_i, scale_i, out_ready,
    input  in_ready, out_valid, result_o
  );

  modport slave (
    input  gemm_uno, in_valid, x_i, y_i, scale_i, out_ready,
    output in_ready, out_valid, result_o
  );
endinterface

// File: rtl/uno_horner_seq.sv
// Iterative Horner evaluator for div/exp/log on frac(x), scaled, plus single-multiply gemm.
// Define SAT_EN to saturate every product/sum reduction instead of wrapping.
module uno_horner_seq #(
  parameter int unsigned INT_BW = 5,
  parameter int unsigned FRA_BW = 10,
  parameter int unsigned MUL_BW = 16,
  parameter int unsigned TERMS  = 4   // legal range 2..4
) (
  input logic             clk,
  input logic             rst_n,
  uno_horner_seq_if.slave uno_io
);

  localparam int unsigned PW = 2 * MUL_BW;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHorner = 2'd1;
  localparam logic [1:0] StScale  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] OpGemm = 2'b00;
  localparam logic [1:0] OpDiv  = 2'b01;
  localparam logic [1:0] OpExp  = 2'b10;
  localparam logic [1:0] OpLog  = 2'b11;

  // Narrow a wide signed value to MUL_BW bits (saturate or wrap).
  function automatic logic [MUL_BW-1:0] reduce(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] max_v;
    logic signed [PW-1:0] min_v;
    logic [MUL_BW-1:0]    res;
    max_v = {{(MUL_BW + 1){1'b0}}, {(MUL_BW - 1){1'b1}}};
    min_v = {{(MUL_BW + 1){1'b1}}, {(MUL_BW - 1){1'b0}}};
`ifdef SAT_EN
    if (v > max_v) begin
      res = max_v[MUL_BW-1:0];
    end else if (v < min_v) begin
      res = min_v[MUL_BW-1:0];
    end else begin
      res = v[MUL_BW-1:0];
    end
`else
    begin : wrap_blk
      logic unused_bits;
      unused_bits = ^{v[PW-1:MUL_BW], max_v, min_v};
      res = v[MUL_BW-1:0];
    end
`endif
    return res;
  endfunction

  // Q5.10 coefficient ROM, c0..c3 per unary op.
  function automatic logic [MUL_BW-1:0] coef(input logic [1:0] op, input logic [1:0] idx);
    logic signed [15:0] c;
    c = 16'sh0000;
    case ({op, idx})
      {OpDiv, 2'd0}: c = 16'sh0400;
      {OpDiv, 2'd1}: c = 16'shFC00;
      {OpDiv, 2'd2}: c = 16'sh0400;
      {OpDiv, 2'd3}: c = 16'shFC00;
      {OpExp, 2'd0}: c = 16'sh0400;
      {OpExp, 2'd1}: c = 16'sh0400;
      {OpExp, 2'd2}: c = 16'sh0200;
      {OpExp, 2'd3}: c = 16'sh00AB;
      {OpLog, 2'd0}: c = 16'sh0000;
      {OpLog, 2'd1}: c = 16'sh0400;
      {OpLog, 2'd2}: c = 16'shFE00;
      {OpLog, 2'd3}: c = 16'sh0155;
      default:       c = 16'sh0000;
    endcase
    return MUL_BW'(c);
  endfunction

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [MUL_BW-1:0] acc_q, acc_d;
  logic [MUL_BW-1:0] r_q, r_d;
  logic [MUL_BW-1:0] sc_q, sc_d;
  logic [MUL_BW-1:0] result_q, result_d;

  // Shared multiplier: acc*r while iterating, acc*sc in the scale step.
  logic [MUL_BW-1:0]    mul_b;
  logic signed [PW-1:0] mul_a_ext;
  logic signed [PW-1:0] mul_b_ext;
  logic signed [PW-1:0] mul_full;
  logic signed [PW-1:0] mul_shift;
  logic [MUL_BW-1:0]    mul_red;
  logic [MUL_BW-1:0]    coef_k;
  logic [MUL_BW:0]      sum_full;
  logic [MUL_BW-1:0]    sum_red;

  always_comb begin
    mul_b     = (state_q == StScale) ? sc_q : r_q;
    mul_a_ext = {{MUL_BW{acc_q[MUL_BW-1]}}, acc_q};
    mul_b_ext = {{MUL_BW{mul_b[MUL_BW-1]}}, mul_b};
    mul_full  = mul_a_ext * mul_b_ext;
    mul_shift = mul_full >>> FRA_BW;
    mul_red   = reduce(mul_shift);
    coef_k    = coef(op_q, k_q);
    sum_full  = {mul_red[MUL_BW-1], mul_red} + {coef_k[MUL_BW-1], coef_k};
    sum_red   = reduce({{(PW - MUL_BW - 1){sum_full[MUL_BW]}}, sum_full});
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    k_d      = k_q;
    acc_d    = acc_q;
    r_d      = r_q;
    sc_d     = sc_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (uno_io.in_valid) begin
          op_d = uno_io.gemm_uno;
          r_d  = {{(MUL_BW - FRA_BW){1'b0}}, uno_io.x_i[FRA_BW-1:0]};
          if (uno_io.gemm_uno == OpGemm) begin
            acc_d   = uno_io.x_i;
            sc_d    = uno_io.y_i;
            state_d = StScale;
          end else begin
            acc_d   = coef(uno_io.gemm_uno, 2'(TERMS - 1));
            sc_d    = uno_io.scale_i;
            k_d     = 2'(TERMS - 2);
            state_d = StHorner;
          end
        end
      end
      StHorner: begin
        acc_d = sum_red;
        if (k_q == 2'd0) begin
          state_d = StScale;
        end else begin
          k_d = k_q - 2'd1;
        end
      end
      StScale: begin
        result_d = mul_red;
        state_d  = StDone;
      end
      StDone: begin
        if (uno_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      sc_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      r_q      <= r_d;
      sc_q     <= sc_d;
      result_q <= result_d;
    end
  end

  assign uno_io.in_ready  = (state_q == StIdle);
  assign uno_io.out_valid = (state_q == StDone);
  assign uno_io.result_o  = result_q;

endmodule

// File: tb/tb_uno_horner_seq.sv
// Scoreboard bench for uno_horner_seq: directed ops push expected results, a monitor checks them.
module tb_uno_horner_seq;
  localparam int unsigned MUL_BW = 16;
  localparam int unsigned TERMS  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uno_horner_seq_if #(.MUL_BW(MUL_BW)) bus ();

  uno_horner_seq #(
    .INT_BW(5),
    .FRA_BW(10),
    .MUL_BW(MUL_BW),
    .TERMS (TERMS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .uno_io(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

`ifdef SAT_EN
  localparam logic [15:0] SatExp = 16'h7FFF;
`else
  localparam logic [15:0] SatExp = 16'hFFFE;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge when valid&ready at the falling edge.
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h, want none", bus.result_o);
        end else begin
          e = exp_q.pop_front();
          check("result", {16'h0, bus.result_o}, {16'h0, e});
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] sc);
    check("in_ready_before_accept", {31'h0, bus.in_ready}, 32'd1);
    bus.gemm_uno = op;
    bus.x_i      = x;
    bus.y_i      = y;
    bus.scale_i  = sc;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int lat);
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(name, cnt, lat);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [15:0] x,
                     input logic [15:0] y, input logic [15:0] sc, input logic [15:0] expv,
                     input int lat);
    exp_q.push_back(expv);
    send(op, x, y, sc);
    wait_valid({name, "_latency"}, lat);
    @(posedge clk);
    #1;
    check({name, "_in_ready_after"}, {31'h0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.gemm_uno  = 2'b00;
    bus.in_valid  = 1'b0;
    bus.x_i       = '0;
    bus.y_i       = '0;
    bus.scale_i   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_result", {16'h0, bus.result_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // gemm edge-by-edge timing with consumer stalled until E1
    exp_q.push_back(16'hFA00);
    send(2'b00, 16'h0600, 16'hFC00, 16'h1234);
    check("gemm_e0_in_ready", {31'h0, bus.in_ready}, 32'd0);
    check("gemm_e0_out_valid", {31'h0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("gemm_e1_out_valid", {31'h0, bus.out_valid}, 32'd1);
    check("gemm_e1_in_ready", {31'h0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("gemm_e2_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("gemm_e2_in_ready", {31'h0, bus.in_ready}, 32'd1);

    run("exp_half", 2'b10, 16'h0200, 16'hAAAA, 16'h0400, 16'h0695, TERMS);
    run("exp_negx", 2'b10, 16'hFE00, 16'h5555, 16'h0400, 16'h0695, TERMS);
    run("exp_negsc", 2'b10, 16'h0200, 16'h0000, 16'hFC00, 16'hF96B, TERMS);
    run("div_zero", 2'b01, 16'h0000, 16'h7777, 16'h0300, 16'h0300, TERMS);
    run("log_zero", 2'b11, 16'h0000, 16'h7777, 16'hFFFF, 16'h0000, TERMS);
    run("log_half", 2'b11, 16'h0200, 16'h0000, 16'h0400, 16'h01AA, TERMS);
    run("gemm_floor", 2'b00, 16'h0001, 16'hFC00, 16'h4321, 16'hFFFF, 1);
    run("gemm_ovf", 2'b00, 16'h7FFF, 16'h0800, 16'h4321, SatExp, 1);

    // Stall in DONE for 10 cycles while in_valid is asserted
    bus.out_ready = 1'b0;
    exp_q.push_back(16'h0300);
    send(2'b01, 16'h0000, 16'h0000, 16'h0300);
    wait_valid("hold_latency", TERMS);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.gemm_uno = 2'b00;
      bus.x_i      = 16'h1234;
      @(posedge clk);
      #1;
      check("hold_result", {16'h0, bus.result_o}, 32'h0300);
      check("hold_out_valid", {31'h0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'h0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_in_ready", {31'h0, bus.in_ready}, 32'd1);
    run("gemm_after_hold", 2'b00, 16'h0600, 16'hFC00, 16'h0000, 16'hFA00, 1);

    // Synchronous reset at E2 of an exp op discards it
    send(2'b10, 16'h0200, 16'h0000, 16'h0400);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("abort_result", {16'h0, bus.result_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("exp_after_abort", 2'b10, 16'h0200, 16'h0000, 16'h0400, 16'h0695, TERMS);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
